ram_cmd_arbiter: RTL and testbench
==================================

# ram_cmd_arbiter

Two-port arbiter and sequencer in front of the single-port command-driven RAM. It accepts complete read/write transactions from two requesters (the SPI-slave path and a local host path), grants them round-robin, and serialises each into the RAM's two-command protocol (address command, then data/read command) on its shared `din`/`rx_valid` input. It returns read data and a completion pulse to the granted requester.

## Interface
- `ADDR_SIZE`, 8, address and data width; RAM command word is `ADDR_SIZE+2` bits.
- `TIMEOUT`, 15, maximum cycles in WAIT_RD for `ram_tx_valid` before aborting.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 2: per-requester transaction request, level; bit i = requester i.
- `op` in 2: per-requester opcode, 0 = write, 1 = read.
- `addr` in 2*ADDR_SIZE: requester i address at `[i*ADDR_SIZE +: ADDR_SIZE]`.
- `wdata` in 2*ADDR_SIZE: requester i write data, same slicing.
- `gnt` out 2: one-hot, high for the granted requester from grant to done inclusive.
- `done` out 2: one-cycle completion pulse to the granted requester.
- `err` out 1: valid with `done`; 1 = read timed out.
- `rdata` out ADDR_SIZE: read data, valid with `done`, held until next read completes.
- `busy` out 1: high in every state except IDLE.
- `ram_din` out ADDR_SIZE+2: command word to RAM, `{cmd[1:0], payload}`.
- `ram_rx_valid` out 1: command strobe to RAM.
- `ram_dout` in ADDR_SIZE: RAM read data.
- `ram_tx_valid` in 1: RAM read-data valid.

## Operation
- RAM commands: 00 = write address, 01 = write data, 10 = read address, 11 = read data request (payload ignored, drive 0).
- FSM states: IDLE, ADDR, DATA, WAIT_RD, DONE.
- IDLE: if any `req` set, select winner, latch its `op`/`addr`/`wdata`, set `gnt`, go ADDR. Otherwise stay.
- ADDR: drive `{op?10:00, addr}`, `ram_rx_valid`=1, go DATA.
- DATA: write drives `{01, wdata}`; read drives `{11, 0}`; `ram_rx_valid`=1. Write goes DONE, read goes WAIT_RD.
- WAIT_RD: `ram_rx_valid`=0. When `ram_tx_valid`=1, latch `ram_dout` into `rdata` and go DONE with `err`=0. If `TIMEOUT` cycles elapse first, go DONE with `err`=1 and `rdata` unchanged.
- DONE: pulse `done[i]`, drop `gnt` next cycle, toggle round-robin pointer away from the served requester, go IDLE.
- `ram_tx_valid` from an earlier read is stale, but the ADDR command clears it in the RAM before WAIT_RD samples it. No masking is required.
- Arbitration: a lone requester wins. If both request, the pointer wins. The pointer resets to requester 0.
- Requester holds `req` high until `done`. If `req` is still high in the IDLE cycle after DONE, it is a new transaction.
- Inputs are sampled only in IDLE. Changes mid-transaction are ignored.
- `ram_rx_valid` is never high in two consecutive transactions without an intervening IDLE cycle.

## Timing
- All outputs are registered.
- Reset values: `gnt`=0, `done`=0, `err`=0, `rdata`=0, `busy`=0, `ram_din`=0, `ram_rx_valid`=0, state IDLE, pointer 0, timeout counter 0.
- With `req` sampled at edge T:
  - ADDR command is visible in cycle T+1.
  - DATA command is visible in T+2.
  - Write `done` occurs in T+3.
  - Read: RAM responds in T+3 and `done`/`rdata` occur in T+4.
- Throughput: write is 4 cycles per transaction including IDLE; read is 5 cycles per transaction.
- Reset mid-transaction: the next edge forces IDLE and all outputs to reset values. No partial command is completed. The RAM's stale address registers are harmless because every transaction re-sends its address.

## Structure
- Shared package `ram_cmd_pkg` holds:
  - the command encodings `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`;
  - the FSM state encoding;
  - the `OP_WRITE`/`OP_READ` constants.
- One sub-module, `rr_arb2`: a two-way round-robin grant with pointer update on a `advance` strobe.

## Test plan
- Req0 write addr 0x12, data 0xA5 → `ram_din` 0x012 at T+1, 0x1A5 at T+2, `done[0]` at T+3, `err`=0.
- Write 0x3C to 0x40, then requester 1 reads 0x40 → `ram_din` 0x240, then 0x300, then `rdata`=0x3C with `done[1]` at T+4.
- Both `req` high with pointer 0, and both held → served 0,1,0,1 alternately; `gnt` always one-hot.
- Read with `ram_tx_valid` forced 0 → `done` with `err`=1 exactly `TIMEOUT` cycles after entering WAIT_RD; `rdata` unchanged.
- `rst` asserted in DATA of a write → next cycle all outputs are at reset values; a subsequent read of that address returns the old data.

Source files
------------

// File: rtl/ram_cmd_pkg.sv
// ram_cmd_pkg: shared command encodings, opcodes and FSM states for the RAM command arbiter
package ram_cmd_pkg;
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;
   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;
   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_WAIT_RD, ST_DONE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; pointer moves away from the served requester on advance
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       served,
   output logic [1:0] gnt,
   output logic       sel
);
   logic ptr;
   always_ff @(posedge clk) begin
      if (rst) ptr <= 1'b0;
      else if (advance) ptr <= ~served;
   end
   always_comb begin
      sel = (req == 2'b11) ? ptr : req[1];
      gnt = (req == 2'b00) ? 2'b00 : (sel ? 2'b10 : 2'b01);
   end
endmodule

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: round-robin two-requester front end serialising transactions into RAM commands
module ram_cmd_arbiter
   import ram_cmd_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req,
   input  logic [1:0]             op,
   input  logic [2*ADDR_SIZE-1:0] addr,
   input  logic [2*ADDR_SIZE-1:0] wdata,
   output logic [1:0]             gnt,
   output logic [1:0]             done,
   output logic                   err,
   output logic [ADDR_SIZE-1:0]   rdata,
   output logic                   busy,
   output logic [ADDR_SIZE+1:0]   ram_din,
   output logic                   ram_rx_valid,
   input  logic [ADDR_SIZE-1:0]   ram_dout,
   input  logic                   ram_tx_valid
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t               state;
   logic                 op_r, sel;
   logic [1:0]           win;
   logic [ADDR_SIZE-1:0] wdata_r, sel_addr, sel_wdata;
   logic [CW-1:0]        cnt;
   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (state == ST_DONE),
      .served  (gnt[1]),
      .gnt     (win),
      .sel     (sel)
   );
   assign sel_addr  = sel ? addr[2*ADDR_SIZE-1:ADDR_SIZE]  : addr[ADDR_SIZE-1:0];
   assign sel_wdata = sel ? wdata[2*ADDR_SIZE-1:ADDR_SIZE] : wdata[ADDR_SIZE-1:0];
   // Commands are registered one state ahead so each appears in the cycle its state is active
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         gnt          <= '0;
         done         <= '0;
         err          <= 1'b0;
         rdata        <= '0;
         busy         <= 1'b0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         op_r         <= OP_WRITE;
         wdata_r      <= '0;
         cnt          <= '0;
      end else begin
         done         <= '0;
         ram_rx_valid <= 1'b0;
         ram_din      <= '0;
         case (state)
            ST_IDLE: if (|req) begin
               state        <= ST_ADDR;
               gnt          <= win;
               busy         <= 1'b1;
               op_r         <= op[sel];
               wdata_r      <= sel_wdata;
               ram_din      <= {op[sel] ? CMD_RD_ADDR : CMD_WR_ADDR, sel_addr};
               ram_rx_valid <= 1'b1;
            end
            ST_ADDR: begin
               state        <= ST_DATA;
               ram_din      <= op_r ? {CMD_RD_DATA, {ADDR_SIZE{1'b0}}} : {CMD_WR_DATA, wdata_r};
               ram_rx_valid <= 1'b1;
            end
            ST_DATA: if (op_r == OP_READ) begin
               state <= ST_WAIT_RD;
               cnt   <= '0;
            end else begin
               state <= ST_DONE;
               done  <= gnt;
               err   <= 1'b0;
            end
            ST_WAIT_RD: if (ram_tx_valid) begin
               state <= ST_DONE;
               done  <= gnt;
               err   <= 1'b0;
               rdata <= ram_dout;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state <= ST_DONE;
               done  <= gnt;
               err   <= 1'b1;
            end else cnt <= cnt + 1'b1;
            ST_DONE: begin
               state <= ST_IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb_ram_cmd_arbiter: random two-requester traffic against a transaction-level reference model
module tb_ram_cmd_arbiter;
   localparam int A  = 8;
   localparam int TO = 15;
   logic clk = 1'b0, rst = 1'b1, ram_clr = 1'b1, mute = 1'b0;
   logic [1:0] req = '0, op = '0;
   logic [2*A-1:0] addr = '0, wdata = '0;
   logic [1:0] gnt, done;
   logic err, busy, ram_rx_valid;
   logic [A-1:0] rdata;
   logic [A+1:0] ram_din;
   logic [A-1:0] ram_dout = '0;
   logic ram_tx_valid = 1'b0;
   logic [A-1:0] mem [256];
   logic [A-1:0] ram_wa = '0, ram_ra = '0;
   int checks = 0, failures = 0;

   ram_cmd_arbiter #(.ADDR_SIZE(A), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
      .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
      .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
   );

   always #5 clk = ~clk;

   // RAM: shares the reset, so it ignores commands on reset edges but keeps its contents
   always @(posedge clk) begin
      if (ram_clr) begin
         foreach (mem[i]) mem[i] <= '0;
      end else if (!rst && ram_rx_valid) begin
         case (ram_din[A+1:A])
            2'b00: ram_wa <= ram_din[A-1:0];
            2'b01: mem[ram_wa] <= ram_din[A-1:0];
            2'b10: begin ram_ra <= ram_din[A-1:0]; ram_tx_valid <= 1'b0; end
            default: if (!mute) begin ram_tx_valid <= 1'b1; ram_dout <= mem[ram_ra]; end
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic issue(input int i, input logic o, input logic [A-1:0] a, input logic [A-1:0] d);
      op[i] = o;
      addr[i*A +: A] = a;
      wdata[i*A +: A] = d;
      req[i] = 1'b1;
   endtask

   logic [A-1:0] ref_mem [256];
   logic [A-1:0] last_rd = '0, m_addr = '0, m_wd = '0;
   logic ptr = 1'b0, m_op = 1'b0, m_mute = 1'b0, fmute = 1'b0, m_busy = 1'b0;
   logic [1:0] m_oh = '0;
   int k = 0, m_free = 0, m_start = 0, m_done_at = 0, m_who = 0, phase = 0, di = 0;

   initial begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      while (phase != 6 && k < 4000) begin
         @(negedge clk);
         k++;
         if (rst) begin
            chk("rst_gnt", gnt, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
            chk("rst_rdata", rdata, 0); chk("rst_busy", busy, 0);
            chk("rst_din", ram_din, 0); chk("rst_rxv", ram_rx_valid, 0);
            m_busy = 1'b0; ptr = 1'b0; last_rd = '0; m_free = k + 1; req = '0; mute = 1'b0;
         end else begin
            if (!m_busy && k >= m_free && req != 2'b00) begin
               m_who = (req == 2'b11) ? int'(ptr) : int'(req[1]);
               m_oh = (m_who == 1) ? 2'b10 : 2'b01;
               m_busy = 1'b1; m_start = k;
               m_op = op[m_who]; m_addr = addr[m_who*A +: A]; m_wd = wdata[m_who*A +: A];
               m_mute = m_op && (fmute || (phase == 1 && $urandom_range(7) == 0));
               mute = m_mute; fmute = 1'b0;
               m_done_at = k + (!m_op ? 2 : (m_mute ? 2 + TO : 3));
               ptr = (m_who == 0);
            end
            chk("gnt", gnt, (m_busy && k >= m_start) ? m_oh : 2'b00);
            chk("busy", busy, m_busy && k >= m_start);
            chk("done", done, (m_busy && k == m_done_at) ? m_oh : 2'b00);
            chk("rx_valid", ram_rx_valid, m_busy && (k == m_start || k == m_start + 1));
            if (m_busy && k == m_start) chk("addr_cmd", ram_din, {m_op ? 2'b10 : 2'b00, m_addr});
            if (m_busy && k == m_start + 1) chk("data_cmd", ram_din, m_op ? {2'b11, 8'h00} : {2'b01, m_wd});
            if (m_busy && k == m_done_at) begin
               chk("err", err, m_mute);
               if (m_op && !m_mute) last_rd = ref_mem[m_addr];
               if (!m_op) ref_mem[m_addr] = m_wd;
               req[m_who] = 1'b0;
               m_busy = 1'b0;
               m_free = m_done_at + 2;
            end
            chk("rdata", rdata, last_rd);
         end
         if (k == 3) begin rst = 1'b0; ram_clr = 1'b0; end
         if (k >= 3) case (phase)
            0: if (!m_busy && req == 2'b00) begin
               case (di)
                  0: issue(0, 1'b0, 8'h12, 8'hA5);
                  1: issue(0, 1'b0, 8'h40, 8'h3C);
                  2: issue(1, 1'b1, 8'h40, 8'h00);
                  3: begin issue(1, 1'b1, 8'h40, 8'h00); fmute = 1'b1; end
                  4: begin issue(0, 1'b0, 8'h50, 8'h11); issue(1, 1'b0, 8'h51, 8'h22); end
                  5: begin issue(0, 1'b1, 8'h51, 8'h00); issue(1, 1'b1, 8'h50, 8'h00); end
                  default: phase = 1;
               endcase
               di++;
            end
            1: if (k < 1500) begin
               for (int i = 0; i < 2; i++)
                  if (!req[i] && $urandom_range(2) == 0)
                     issue(i, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
            end else if (!m_busy && req == 2'b00) phase = 2;
            2: if (k >= m_free) begin issue(0, 1'b0, 8'h40, 8'h99); phase = 3; end
            3: if (m_busy && k == m_start + 1) begin rst = 1'b1; phase = 4; end
            4: begin rst = 1'b0; issue(1, 1'b1, 8'h40, 8'h00); phase = 5; end
            5: if (!m_busy && req == 2'b00) begin chk("post_rst_read", rdata, 8'h3C); phase = 6; end
            default: ;
         endcase
      end
      chk("finished", phase, 6);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
